// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: types and constants shared by the FIFO write arbiter and its helpers.
// Holds the FSM state encoding, the beat-counter width and the statistics saturation helper.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int BEAT_W = 4;
   typedef logic [BEAT_W-1:0] beat_cnt_t;

   localparam logic [15:0] STAT_MAX = 16'hFFFF;

   // Saturating increment for the 16-bit per-requester beat statistics.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == STAT_MAX) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: round-robin selector returning the first set request bit after i_last, wrapping.
// Scans downward so the candidate closest to i_last+1 is the last one assigned and wins.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [IDX_W:0] w_sum;
   logic [IDX_W:0] w_cand;

   always_comb begin
      o_idx  = '0;
      w_sum  = '0;
      w_cand = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_sum  = {1'b0, i_last} + (IDX_W+1)'(i);
         w_cand = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? (w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum;
         if (i_req[w_cand[IDX_W-1:0]]) begin
            o_idx = w_cand[IDX_W-1:0];
         end else begin
            o_idx = o_idx;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter funnelling NUM_REQ write streams into one FIFO port.
// Optional feature macro FIFO_ARB_STATS_EN adds stat_beats, per-requester saturating write counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   input  logic                          fifo_full,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         stat_beats
`endif
);

   localparam int GW = $clog2(NUM_REQ);

   arb_state_t  r_state;
   arb_state_t  w_next_state;
   logic [GW-1:0] r_last_grant;
   logic [GW-1:0] r_grant_id;
   beat_cnt_t   r_beat_cnt;

   logic [GW-1:0] w_pick_idx;
   logic          w_pick_any;
   logic          w_gnt_valid;
   logic          w_beat_ok;
   logic          w_write;
   logic          w_last_beat;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GW)
   ) u_rr_pick (
      .i_req  (req_valid),
      .i_last (r_last_grant),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   assign w_gnt_valid = req_valid[r_grant_id];
   assign w_beat_ok   = (r_state == ST_BURST) && w_gnt_valid && !fifo_full;
   // Reset gates the write so a burst interrupted by rst never transfers in that cycle.
   assign w_write     = w_beat_ok && rst;
   assign w_last_beat = ((r_beat_cnt + BEAT_W'(1)) == BEAT_W'(MAX_BURST));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_next_state = ST_BURST;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (!w_gnt_valid) begin
               w_next_state = ST_IDLE;
            end else if (w_beat_ok && w_last_beat) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_BURST;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      fifo_wr_en = 1'b0;
      req_ready  = '0;
      busy       = 1'b0;
      if (rst && (r_state == ST_BURST)) begin
         busy                  = 1'b1;
         fifo_wr_en            = w_write;
         req_ready[r_grant_id] = w_write;
      end else begin
         busy = 1'b0;
      end
   end

   assign fifo_wr_data = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign grant_id     = r_grant_id;

   // Grant capture happens only on the IDLE arbitration cycle; the beat count restarts there too.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last_grant <= GW'(NUM_REQ - 1);
         r_grant_id   <= '0;
         r_beat_cnt   <= '0;
      end else if ((r_state == ST_IDLE) && w_pick_any) begin
         r_last_grant <= w_pick_idx;
         r_grant_id   <= w_pick_idx;
         r_beat_cnt   <= '0;
      end else if (w_write) begin
         r_last_grant <= r_last_grant;
         r_grant_id   <= r_grant_id;
         r_beat_cnt   <= r_beat_cnt + BEAT_W'(1);
      end else begin
         r_last_grant <= r_last_grant;
         r_grant_id   <= r_grant_id;
         r_beat_cnt   <= r_beat_cnt;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] r_stat_beats;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stat_beats <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_write && (r_grant_id == GW'(i))) begin
               r_stat_beats[i*16 +: 16] <= sat_inc16(r_stat_beats[i*16 +: 16]);
            end else begin
               r_stat_beats[i*16 +: 16] <= r_stat_beats[i*16 +: 16];
            end
         end
      end
   end

   assign stat_beats = r_stat_beats;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven directed bench for fifo_wr_arbiter (NUM_REQ 3, 8-bit data, MAX_BURST 4).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_fifo_wr_arbiter;

   localparam int NR = 3;
   localparam int DW = 8;
   localparam int MB = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             fifo_wr_en;
   logic [DW-1:0]    fifo_wr_data;
   logic             fifo_full;
   logic [1:0]       grant_id;
   logic             busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NR*16-1:0] stat_beats;
`endif

   int checks = 0;
   int errors = 0;
   int nw;

   typedef struct {
      logic        rst;
      logic [2:0]  valid;
      logic [23:0] data;
      logic        full;
      logic        wr;
      logic [7:0]  wdata;
      logic [2:0]  ready;
      logic [1:0]  gid;
      logic        busy;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .grant_id     (grant_id),
      .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_beats   (stat_beats)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [2:0] v, input logic [23:0] d, input logic f,
                      input logic wr, input logic [7:0] wd, input logic [2:0] rdy,
                      input logic [1:0] gid, input logic bsy);
      vec_t e;
      e.rst = r; e.valid = v; e.data = d; e.full = f;
      e.wr = wr; e.wdata = wd; e.ready = rdy; e.gid = gid; e.busy = bsy;
      vecs.push_back(e);
   endtask

   task automatic drive(input logic r, input logic [2:0] v, input logic [23:0] d, input logic f);
      @(posedge clk);
      #1;
      rst       = r;
      req_valid = v;
      req_data  = d;
      fifo_full = f;
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic wr, input logic [7:0] wd,
                             input logic [2:0] rdy, input logic [1:0] gid, input logic bsy);
      check({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(wr));
      check({tag, ".ready"}, 64'(req_ready), 64'(rdy));
      check({tag, ".grant_id"}, 64'(grant_id), 64'(gid));
      check({tag, ".busy"}, 64'(busy), 64'(bsy));
      if (wr) begin
         check({tag, ".wr_data"}, 64'(fifo_wr_data), 64'(wd));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [23:0] d1;
      logic [23:0] d3;
      logic [23:0] dfull;
      logic [23:0] drst;
      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      d1    = 24'h00A500;
      d3    = 24'h332211;
      dfull = 24'h5C0000;
      drst  = 24'h00B1B0;

      // Reset, then requester 1 alone sends one 8'hA5 beat and drops valid.
      add(1'b0, 3'b000, 24'h0, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      add(1'b0, 3'b000, 24'h0, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      add(1'b1, 3'b010, d1,    1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      add(1'b1, 3'b010, d1,    1'b0, 1'b1, 8'hA5, 3'b010, 2'd1, 1'b1);
      add(1'b1, 3'b000, d1,    1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b1);
      add(1'b1, 3'b000, d1,    1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b0);
      // Reset with everybody valid: outputs forced low, then bursts of 4 in order 0,1,2,0.
      add(1'b0, 3'b111, d3,    1'b0, 1'b0, 8'h00, 3'b000, 2'd1, 1'b0);
      add(1'b1, 3'b111, d3,    1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      for (int b = 0; b < 4; b++) begin
         int g;
         g = b % 3;
         for (int k = 0; k < MB; k++) begin
            add(1'b1, 3'b111, d3, 1'b0, 1'b1, 8'(17 * (g + 1)), 3'(1 << g), 2'(g), 1'b1);
         end
         add(1'b1, (b == 3) ? 3'b000 : 3'b111, d3, 1'b0, 1'b0, 8'h00, 3'b000, 2'(g), 1'b0);
      end
      add(1'b1, 3'b000, d3,    1'b0, 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].valid, vecs[k].data, vecs[k].full);
         expect_out($sformatf("vec%0d", k), vecs[k].wr, vecs[k].wdata, vecs[k].ready,
                    vecs[k].gid, vecs[k].busy);
      end

      // fifo_full stall mid-burst on requester 2, then regrant of a lone requester.
      drive(1'b1, 3'b100, dfull, 1'b0);
      expect_out("full_arb", 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      nw = 0;
      for (int c = 0; c < 7; c++) begin
         logic f;
         f = (c >= 2 && c <= 4);
         drive(1'b1, 3'b100, dfull, f);
         if (f) begin
            expect_out($sformatf("full_stall%0d", c), 1'b0, 8'h00, 3'b000, 2'd2, 1'b1);
         end else begin
            expect_out($sformatf("full_beat%0d", c), 1'b1, 8'h5C, 3'b100, 2'd2, 1'b1);
         end
         if (fifo_wr_en) nw++;
      end
      check("full_total_writes", 64'(nw), 64'(4));
      drive(1'b1, 3'b100, dfull, 1'b0);
      expect_out("alone_idle", 1'b0, 8'h00, 3'b000, 2'd2, 1'b0);
      drive(1'b1, 3'b100, dfull, 1'b0);
      expect_out("alone_regrant", 1'b1, 8'h5C, 3'b100, 2'd2, 1'b1);
      drive(1'b1, 3'b000, dfull, 1'b0);
      expect_out("alone_drop", 1'b0, 8'h00, 3'b000, 2'd2, 1'b1);
      drive(1'b1, 3'b000, dfull, 1'b0);
      expect_out("alone_end", 1'b0, 8'h00, 3'b000, 2'd2, 1'b0);

      // Reset on beat 2 of a requester-1 burst; afterwards requester 0 wins first.
      drive(1'b1, 3'b010, drst, 1'b0);
      expect_out("rst_arb", 1'b0, 8'h00, 3'b000, 2'd2, 1'b0);
      drive(1'b1, 3'b010, drst, 1'b0);
      expect_out("rst_beat1", 1'b1, 8'hB1, 3'b010, 2'd1, 1'b1);
      drive(1'b0, 3'b010, drst, 1'b0);
      expect_out("rst_beat2", 1'b0, 8'h00, 3'b000, 2'd1, 1'b0);
      drive(1'b1, 3'b011, drst, 1'b0);
      expect_out("rst_release", 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);
      drive(1'b1, 3'b011, drst, 1'b0);
      expect_out("rst_regrant0", 1'b1, 8'hB0, 3'b001, 2'd0, 1'b1);
      drive(1'b1, 3'b000, drst, 1'b0);
      expect_out("rst_drop", 1'b0, 8'h00, 3'b000, 2'd0, 1'b1);
      drive(1'b1, 3'b000, drst, 1'b0);
      expect_out("rst_idle", 1'b0, 8'h00, 3'b000, 2'd0, 1'b0);

`ifdef FIFO_ARB_STATS_EN
      // Requester 2 alone performs exactly 10 writes; only its counter moves.
      drive(1'b0, 3'b000, 24'h0, 1'b0);
      drive(1'b0, 3'b000, 24'h0, 1'b0);
      check("stat_reset", 64'(stat_beats), 64'(0));
      nw = 0;
      for (int c = 0; c < 40 && nw < 10; c++) begin
         drive(1'b1, 3'b100, 24'h770000, 1'b0);
         if (fifo_wr_en) nw++;
      end
      check("stat_writes_seen", 64'(nw), 64'(10));
      drive(1'b1, 3'b000, 24'h770000, 1'b0);
      drive(1'b1, 3'b000, 24'h770000, 1'b0);
      check("stat_req2", 64'(stat_beats[32 +: 16]), 64'(10));
      check("stat_req1", 64'(stat_beats[16 +: 16]), 64'(0));
      check("stat_req0", 64'(stat_beats[0 +: 16]), 64'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, requester and FIFO data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester data valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; beat transfers when valid and ready are both high.
REQ-009 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-010 SHALL have port fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-011 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  currently or last granted requester.
REQ-013 SHALL have port busy  output  1  high while in state BURST.

Function
REQ-014 SHALL implement FSM states IDLE and BURST.
REQ-015 IDLE: when any req_valid is high, SHALL pick the first valid requester searching round-robin from last_grant+1 (wrapping at NUM_REQ-1 to 0), register it as grant_id and last_grant, and enter BURST next cycle; else stay IDLE.
REQ-016 BURST: fifo_wr_en = req_valid[grant_id] && !fifo_full, combinational from registered state; req_ready[grant_id] equals fifo_wr_en; all other req_ready bits are 0.
REQ-017 fifo_wr_data SHALL equal the grant_id slice of req_data at all times in BURST; value is don't-care when fifo_wr_en is 0.
REQ-018 A 4-bit beat counter SHALL increment on each write and clear on entry to BURST.
REQ-019 BURST SHALL exit to IDLE after the write that makes the counter equal MAX_BURST, or in any cycle where req_valid[grant_id] is low.
REQ-020 fifo_full high in BURST with valid high SHALL stall: no write, no counter change, grant held.
REQ-021 Latency: request arriving in IDLE at cycle N SHALL produce its first write at cycle N+1; one idle arbitration cycle SHALL separate consecutive bursts.
REQ-022 In IDLE, fifo_wr_en, busy and all req_ready SHALL be 0.
REQ-023 A single requester with continuous valid SHALL be regranted after each IDLE cycle (no starvation of self when alone).

Reset
REQ-024 With rst low at a clock edge: state IDLE, last_grant = NUM_REQ-1 (requester 0 first), beat counter 0, grant_id 0.
REQ-025 While rst is low, fifo_wr_en, req_ready and busy SHALL be forced 0 combinationally; a burst in progress is abandoned without a write in the reset cycle.

Configuration
REQ-026 Macro FIFO_ARB_STATS_EN defined: SHALL add output stat_beats  NUM_REQ*16  per-requester saturating write-beat counters (reset to 0, saturate at 16'hFFFF).
REQ-027 Macro undefined: port stat_beats and its counters SHALL not exist; all other behaviour is identical.

Structure
REQ-028 FSM state enum and the 4-bit beat-counter width SHALL live in shared package fifo_arb_pkg.
REQ-029 The round-robin selector SHALL be sub-module rr_pick (inputs request vector, last grant; outputs next index, any-valid).

Verification
REQ-030 Reset release, requester 1 valid with data 8'hA5 -> grant_id 1 one cycle later, single write of 8'hA5, exit to IDLE when valid drops.
REQ-031 All 3 requesters continuously valid, MAX_BURST 4 -> bursts of exactly 4 writes in order 0,1,2,0, one idle cycle between bursts.
REQ-032 fifo_full held high 3 cycles mid-burst -> no writes, counter frozen, same grant_id, burst completes remaining beats after full drops.
REQ-033 rst driven low on beat 2 of a burst -> no write that cycle, next grant after release goes to requester 0.
REQ-034 FIFO_ARB_STATS_EN defined, requester 2 completes 10 writes -> stat_beats slice 2 reads 10, others 0.
